// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet dimensions and pool2 state encoding
package lenet_pkg;

    localparam int DATA_SIZE    = 16;
    localparam int CONV2_DEEP   = 16;
    localparam int CONV2_OUTPUT = 8;
    localparam int POOL2_OUTPUT = 4;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_READ  = 5'b00010,
        S_WAIT  = 5'b00100,
        S_WRITE = 5'b01000,
        S_DONE  = 5'b10000
    } pool2_state_t;

endpackage

// File: rtl/pool_max_cmp.sv
// rtl/pool_max_cmp.sv - signed greater-than select between a candidate and the running max
module pool_max_cmp
    import lenet_pkg::*;
#(
    parameter int DATA_SIZE = lenet_pkg::DATA_SIZE
) (
    input  logic [DATA_SIZE-1:0] cand,
    input  logic [DATA_SIZE-1:0] cur,
    output logic [DATA_SIZE-1:0] max_o
);

    logic gt;

    // Strictly greater, so a tie keeps the earlier sample.
    assign gt    = $signed(cand) > $signed(cur);
    assign max_o = gt ? cand : cur;

endmodule

// File: rtl/pool2.sv
// rtl/pool2.sv - 2x2 signed max-pool of conv2 maps into the pool2 result BRAM
module pool2
    import lenet_pkg::*;
#(
    parameter int DATA_SIZE = lenet_pkg::DATA_SIZE,
    parameter int CHANNELS  = CONV2_DEEP,
    parameter int IN_SIZE   = CONV2_OUTPUT,
    parameter int OUT_SIZE  = POOL2_OUTPUT,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_2_en,
    input  logic [DATA_SIZE-1:0] input_bram_douta,
    output logic                 input_bram_ena,
    output logic [9:0]           input_bram_addra,
    output logic                 result_bram_wea,
    output logic [7:0]           result_bram_addra,
    output logic [DATA_SIZE-1:0] result_bram_dina,
    output logic                 pool_2_finish
);

    localparam int CH_W  = $clog2(CHANNELS);
    localparam int RC_W  = $clog2(OUT_SIZE);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);
    localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(OUT_SIZE - 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT - 1);

    pool2_state_t          state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [RC_W-1:0]       r_q, r_d, c_q, c_d;
    logic [1:0]            k_q, k_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [RD_LAT-1:0]     vld_q, vld_d, first_q, first_d;
    logic [DATA_SIZE-1:0]  max_q, max_d, cmp_max;
    logic                  ena_q, ena_d, wea_q, wea_d, fin_q, fin_d;
    logic [9:0]            iaddr_q, iaddr_d;
    logic [7:0]            raddr_q, raddr_d;
    logic [DATA_SIZE-1:0]  dina_q, dina_d;

    pool_max_cmp #(.DATA_SIZE(DATA_SIZE)) u_cmp (
        .cand  (input_bram_douta),
        .cur   (max_q),
        .max_o (cmp_max)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        lat_d   = lat_q;
        max_d   = max_q;
        ena_d   = 1'b0;
        wea_d   = 1'b0;
        fin_d   = fin_q;
        iaddr_d = iaddr_q;
        raddr_d = raddr_q;
        dina_d  = dina_q;

        // Issued reads ripple through the shift register; the tail marks douta valid.
        vld_d[0]   = ena_q;
        first_d[0] = ena_q && (k_q == 2'd0);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            first_d[i] = first_q[i-1];
        end
        if (vld_q[RD_LAT-1]) begin
            max_d = first_q[RD_LAT-1] ? input_bram_douta : cmp_max;
        end

        case (state_q)
            S_IDLE: begin
                if (pool_2_en) begin
                    ch_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    lat_d   = '0;
                    state_d = S_READ;
                    ena_d   = 1'b1;
                    iaddr_d = '0;
                end
            end
            S_READ: begin
                if (k_q == 2'd3) begin
                    state_d = S_WAIT;
                    lat_d   = '0;
                end else begin
                    k_d     = k_q + 2'd1;
                    ena_d   = 1'b1;
                    iaddr_d = {ch_q, r_q, k_d[1], c_q, k_d[0]};
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_MAX) begin
                    state_d = S_WRITE;
                    wea_d   = 1'b1;
                    raddr_d = {ch_q, r_q, c_q};
                    dina_d  = max_d;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE: begin
                k_d = '0;
                c_d = c_q + RC_W'(1);
                if (c_q == RC_MAX) begin
                    r_d = r_q + RC_W'(1);
                    if (r_q == RC_MAX) begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                if (c_q == RC_MAX && r_q == RC_MAX && ch_q == CH_MAX) begin
                    state_d = S_DONE;
                    fin_d   = 1'b1;
                end else begin
                    state_d = S_READ;
                    ena_d   = 1'b1;
                    iaddr_d = {ch_d, r_d, 1'b0, c_d, 1'b0};
                end
            end
            S_DONE: begin
                if (!pool_2_en) begin
                    fin_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            lat_q   <= '0;
            vld_q   <= '0;
            first_q <= '0;
            max_q   <= '0;
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            fin_q   <= 1'b0;
            iaddr_q <= '0;
            raddr_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            max_q   <= max_d;
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            fin_q   <= fin_d;
            iaddr_q <= iaddr_d;
            raddr_q <= raddr_d;
            dina_q  <= dina_d;
        end
    end

    assign input_bram_ena    = ena_q;
    assign input_bram_addra  = iaddr_q;
    assign result_bram_wea   = wea_q;
    assign result_bram_addra = raddr_q;
    assign result_bram_dina  = dina_q;
    assign pool_2_finish     = fin_q;

endmodule

// File: tb/tb_pool2.sv
// tb/tb_pool2.sv - scoreboard bench for pool2 at read latency 2 and 3
module tb_pool2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:1023];

    logic        rst1, en1, ena1, we1, fin1;
    logic [15:0] dout1, di1;
    logic [9:0]  ia1;
    logic [7:0]  ra1;
    logic        rst2, en2, ena2, we2, fin2;
    logic [15:0] dout2, di2;
    logic [9:0]  ia2;
    logic [7:0]  ra2;

    pool2 #(.RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst1), .pool_2_en(en1), .input_bram_douta(dout1),
        .input_bram_ena(ena1), .input_bram_addra(ia1), .result_bram_wea(we1),
        .result_bram_addra(ra1), .result_bram_dina(di1), .pool_2_finish(fin1)
    );

    pool2 #(.RD_LAT(3)) dut2 (
        .clk(clk), .rst(rst2), .pool_2_en(en2), .input_bram_douta(dout2),
        .input_bram_ena(ena2), .input_bram_addra(ia2), .result_bram_wea(we2),
        .result_bram_addra(ra2), .result_bram_dina(di2), .pool_2_finish(fin2)
    );

    logic [15:0] p1 [0:1];
    logic [15:0] p2 [0:2];
    always @(posedge clk) begin
        p1[0] <= ena1 ? mem[ia1] : 16'h5A5A;
        p1[1] <= p1[0];
        p2[0] <= ena2 ? mem[ia2] : 16'h5A5A;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign dout1 = p1[1];
    assign dout2 = p2[2];

    logic [23:0] q1 [$];
    logic [23:0] q2 [$];
    bit          st1 = 0, st2 = 0, we1_prev = 0, we2_prev = 0;
    int unsigned t1, t2;
    int          wr_cnt1 = 0, tie_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_val(input int ch, input int r, input int c, input bit spec);
        int w;
        w = ch * 16 + r * 4 + c;
        if (spec && w == 0) return 16'hFFFD;
        if (spec && w == 1) return 16'h7FFF;
        if (spec && w == 2) return 16'h0003;
        return 16'(ch * 64 + (2 * r + 1) * 8 + 2 * c + 1);
    endfunction

    task automatic push_exp(input int which, input bit spec);
        for (int ch = 0; ch < 16; ch++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (which == 1) q1.push_back({8'(ch * 16 + r * 4 + c), exp_val(ch, r, c, spec)});
                    else            q2.push_back({8'(ch * 16 + r * 4 + c), exp_val(ch, r, c, spec)});
                end
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst1) begin
            if (we1) begin
                wr_cnt1++;
                if (ra1 == 8'd2) tie_cnt++;
                check("excl1", {31'd0, ena1}, 32'd0);
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write1 actual=%h/%h required=no write", ra1, di1);
                end else begin
                    e = q1.pop_front();
                    check("write1", {8'd0, ra1, di1}, {8'd0, e});
                end
                if (we1_prev) begin
                    checks++; failures++;
                    $display("FAIL wea_pulse1 actual=2 cycles required=1");
                end
            end
            if (ena1 && !st1) begin
                st1 = 1; t1 = cyc;
                check("first_addr1", {22'd0, ia1}, 32'd0);
            end
            if (fin1 && st1) begin
                st1 = 0;
                check("finish_lat1", cyc - t1, 32'd1792);
            end
        end
        if (rst2) begin
            if (we2) begin
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write2 actual=%h/%h required=no write", ra2, di2);
                end else begin
                    e = q2.pop_front();
                    check("write2", {8'd0, ra2, di2}, {8'd0, e});
                end
            end
            if (ena2 && !st2) begin
                st2 = 1; t2 = cyc;
                check("first_addr2", {22'd0, ia2}, 32'd0);
            end
            if (fin2 && st2) begin
                st2 = 0;
                check("finish_lat2", cyc - t2, 32'd2048);
            end
        end
        we1_prev = we1;
        we2_prev = we2;
    end

    task automatic wait_fin(input int which);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ((which == 1) ? fin1 : fin2) return;
        end
        checks++; failures++;
        $display("FAIL finish_timeout%0d actual=0 required=1", which);
    endtask

    task automatic wait_start1();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ena1) return;
        end
        checks++; failures++;
        $display("FAIL start_timeout actual=0 required=1");
    endtask

    task automatic set_window(input int base, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        mem[base] = a; mem[base + 1] = b; mem[base + 8] = c; mem[base + 9] = d;
    endtask

    task automatic check_outputs_zero();
        check("rst_ena", {31'd0, ena1}, 32'd0);
        check("rst_iaddr", {22'd0, ia1}, 32'd0);
        check("rst_wea", {31'd0, we1}, 32'd0);
        check("rst_raddr", {24'd0, ra1}, 32'd0);
        check("rst_dina", {16'd0, di1}, 32'd0);
        check("rst_finish", {31'd0, fin1}, 32'd0);
    endtask

    int wc;

    initial begin
        rst1 = 1'b0; rst2 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero();
        check("rst_finish2", {31'd0, fin2}, 32'd0);

        // Ramp on both latencies, enable held high.
        @(posedge clk); #2;
        rst1 = 1'b1; rst2 = 1'b1;
        push_exp(1, 0);
        push_exp(2, 0);
        en1 = 1'b1; en2 = 1'b1;
        wait_fin(1);
        wc = wr_cnt1;
        repeat (10) @(negedge clk);
        check("no_rewrite", wc, wr_cnt1);
        check("finish_held", {31'd0, fin1}, 32'd1);
        wait_fin(2);
        check("drain1", q1.size(), 32'd0);
        check("drain2", q2.size(), 32'd0);
        en2 = 1'b0;

        @(posedge clk); #2;
        en1 = 1'b0;
        @(negedge clk);
        check("finish_before_drop", {31'd0, fin1}, 32'd1);
        @(negedge clk);
        check("finish_after_drop", {31'd0, fin1}, 32'd0);
        repeat (2) @(negedge clk);

        // Signed-compare and tie windows; enable dropped mid-run.
        set_window(0, 16'hFFFB, 16'hFFFD, 16'hFFF9, 16'hFFFC);
        set_window(2, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001);
        set_window(4, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
        tie_cnt = 0;
        push_exp(1, 1);
        @(posedge clk); #2;
        en1 = 1'b1;
        wait_start1();
        repeat (300) @(posedge clk);
        #2 en1 = 1'b0;
        wait_fin(1);
        check("drain_spec", q1.size(), 32'd0);
        check("tie_once", tie_cnt, 32'd1);
        @(negedge clk);
        check("finish_clear_en_low", {31'd0, fin1}, 32'd0);
        repeat (2) @(negedge clk);

        // Reset mid-run, then restart with enable still high.
        push_exp(1, 1);
        @(posedge clk); #2;
        en1 = 1'b1;
        wait_start1();
        repeat (500) @(posedge clk);
        #2 rst1 = 1'b0;
        #1;
        check_outputs_zero();
        q1.delete();
        st1 = 0;
        push_exp(1, 1);
        repeat (3) @(posedge clk);
        #2 rst1 = 1'b1;
        wait_fin(1);
        check("drain_restart", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
